// File: rtl/dmem_pkg.sv
// Shared defaults for the MEM-stage data memory: geometry and the word loaded on reset.
// Optional feature macro used by data_memory: DMEM_BYPASS_EN (write-first read forwarding).
package dmem_pkg;

    localparam int DMEM_DATA_W = 8;
    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DEPTH  = 256;

    localparam logic [DMEM_DATA_W-1:0] DMEM_RESET_WORD = '0;

    // Index width for a DEPTH-entry array; never narrower than one bit.
    function automatic int dmem_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Raw DEPTH x DATA_W register array: synchronous clear, one write port, async read port.
// Write/clear take effect at the clock edge; read is zero-latency; always ready, no backpressure.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int IDX_W  = dmem_idx_w(DMEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Clear beats write: a write presented in the reset cycle is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(DMEM_RESET_WORD);
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_memory.sv
// MEM-stage data memory: range-checked async read, edge-triggered write, sync active-high clear.
// Read latency 0, write visible after the edge; always ready. DMEM_BYPASS_EN forwards WriteData.
module data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData
);

    localparam int IDX_W = dmem_idx_w(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic              in_range;
    logic              arr_we;
    logic [IDX_W-1:0]  arr_idx;
    logic [DATA_W-1:0] arr_rdata;

    // Out-of-range addresses must never alias onto a low index, so the
    // enable is gated here rather than relying on index truncation.
    assign in_range = ({1'b0, ALUResult} < DEPTH_L);
    assign arr_we   = MemWrite && in_range;
    assign arr_idx  = ALUResult[IDX_W-1:0];

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk_i   (CLK),
        .rst_i   (Reset),
        .we_i    (arr_we),
        .addr_i  (arr_idx),
        .wdata_i (WriteData),
        .rdata_o (arr_rdata)
    );

`ifdef DMEM_BYPASS_EN
    assign ReadData = !in_range ? '0 : (MemWrite ? WriteData : arr_rdata);
`else
    assign ReadData = in_range ? arr_rdata : '0;
`endif

    a_memwrite_known : assert property (@(posedge CLK) disable iff (Reset)
        !$isunknown(MemWrite));

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: full-depth instance plus a DEPTH=128 instance for range checks.
module tb_data_memory;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_write;
    logic [7:0] alu_result;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic [7:0] read_data_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_memory dut (
        .CLK       (clk),
        .Reset     (rst),
        .MemWrite  (mem_write),
        .ALUResult (alu_result),
        .WriteData (write_data),
        .ReadData  (read_data)
    );

    data_memory #(.DEPTH(128)) dut_s (
        .CLK       (clk),
        .Reset     (rst),
        .MemWrite  (mem_write),
        .ALUResult (alu_result),
        .WriteData (write_data),
        .ReadData  (read_data_s)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [7:0] addr);
        alu_result = addr;
        #1;
    endtask

    initial begin
        int sweep_bad;
        int sweep_bad_s;
        rst        = 1'b1;
        mem_write  = 1'b0;
        alu_result = 8'd0;
        write_data = 8'd0;
        tick();
        rst = 1'b0;

        sweep_bad   = 0;
        sweep_bad_s = 0;
        for (int a = 0; a < 256; a++) begin
            peek(8'(a));
            if (read_data !== 8'h00)   sweep_bad++;
            if (read_data_s !== 8'h00) sweep_bad_s++;
        end
        check("reset_sweep_256_nonzero_count", 8'(sweep_bad), 8'd0);
        check("reset_sweep_128_nonzero_count", 8'(sweep_bad_s), 8'd0);

        // Idle: data and address wiggle, nothing may be stored.
        mem_write  = 1'b0;
        write_data = 8'h8F;
        alu_result = 8'd7;
        tick();
        tick();
        check("idle_no_write", read_data, 8'h00);

        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        check("write_7", read_data, 8'h8F);
        peek(8'd8);
        check("neighbour_8_untouched", read_data, 8'h00);

        alu_result = 8'd10;
        write_data = 8'hAD;
        mem_write  = 1'b1;
        tick();
        check("write_10", read_data, 8'hAD);

        // Same-address read during write at 7.
        alu_result = 8'd7;
        #1;
`ifdef DMEM_BYPASS_EN
        check("rdw_before_edge", read_data, 8'hAD);
`else
        check("rdw_before_edge", read_data, 8'h8F);
`endif
        tick();
        mem_write = 1'b0;
        check("rdw_after_edge", read_data, 8'hAD);
        peek(8'd10);
        check("readback_10", read_data, 8'hAD);

        // Out of range on the 128-deep instance.
        alu_result = 8'd72;
        write_data = 8'h3C;
        mem_write  = 1'b1;
        tick();
        alu_result = 8'd200;
        write_data = 8'hFF;
        #1;
        check("oor_read_during_write", read_data_s, 8'h00);
        tick();
        mem_write = 1'b0;
        check("oor_read_200_small", read_data_s, 8'h00);
        check("inrange_200_big", read_data, 8'hFF);
        peek(8'd72);
        check("no_alias_72_small", read_data_s, 8'h3C);
        check("no_alias_72_big", read_data, 8'h3C);

        // Reset raised mid-operation: contents hold until the edge.
        rst        = 1'b1;
        mem_write  = 1'b0;
        alu_result = 8'd7;
        #1;
        check("reset_pending_holds_7", read_data, 8'hAD);
        alu_result = 8'd3;
        write_data = 8'h55;
        mem_write  = 1'b1;
        tick();
        rst       = 1'b0;
        mem_write = 1'b0;
        check("reset_prio_3", read_data, 8'h00);
        peek(8'd7);
        check("reset_clears_7", read_data, 8'h00);
        peek(8'd10);
        check("reset_clears_10", read_data, 8'h00);
        peek(8'd72);
        check("reset_clears_72_small", read_data_s, 8'h00);
        peek(8'd200);
        check("reset_clears_200_big", read_data, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
